alu_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_flags.sv | 25 ++
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU sequencer slice.
// Op codes double as the operand-mux select values.
package alu_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_DEC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_flags.sv
// alu_flags: Z/C/V from accumulator, effective B and adder outputs.
// Purely combinational.
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b_eff,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             z,
    output logic             c,
    output logic             v
);

    // Overflow: operands agree in sign, sum sign differs.
    always_comb begin
        z = (sum == '0);
        c = cout;
        v = (acc[WIDTH-1] == b_eff[WIDTH-1])
            && (sum[WIDTH-1] != acc[WIDTH-1]);
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one op through the external mux/adder,
// holds drives for SETTLE cycles, then captures into the accumulator.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_load,
    input  logic [WIDTH-1:0] req_operand,
    output logic [WIDTH-1:0] mux_a,
    output logic             mux_s1,
    output logic             mux_s0,
    output logic [WIDTH-1:0] add_a,
    output logic             add_cin,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_z,
    output logic             resp_c,
    output logic             resp_v,
    output logic [WIDTH-1:0] acc
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mux_a_q, mux_a_d;
    op_e              op_q, op_d;
    logic             cin_q, cin_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic [WIDTH-1:0] b_eff;
    logic             f_z, f_c, f_v;

    // Effective B the adder sees, rebuilt from the latched drives.
    always_comb begin
        b_eff = mux_a_q;
        unique case (op_q)
            OP_ADD: b_eff = mux_a_q;
            OP_SUB: b_eff = ~mux_a_q;
            OP_INC: b_eff = '0;
            OP_DEC: b_eff = '1;
            default: b_eff = mux_a_q;
        endcase
    end

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .acc   (acc_q),
        .b_eff (b_eff),
        .sum   (sum_in),
        .cout  (cout_in),
        .z     (f_z),
        .c     (f_c),
        .v     (f_v)
    );

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mux_a_d = mux_a_q;
        op_d    = op_q;
        cin_d   = cin_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_load) begin
                        acc_d   = req_operand;
                        z_d     = (req_operand == '0);
                        c_d     = 1'b0;
                        v_d     = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        mux_a_d = req_operand;
                        op_d    = op_e'(req_op);
                        cin_d   = req_op[1] ^ req_op[0];
                        cnt_d   = CNT_INIT;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                acc_d   = sum_in;
                z_d     = f_z;
                c_d     = f_c;
                v_d     = f_v;
                mux_a_d = '0;
                op_d    = OP_ADD;
                cin_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; rst aborts any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            acc_q   <= '0;
            mux_a_q <= '0;
            op_q    <= OP_ADD;
            cin_q   <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mux_a_q <= mux_a_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE) && !rst;
    assign resp_valid  = (state_q == ST_RESP);
    assign mux_a       = mux_a_q;
    assign mux_s1      = op_q[1];
    assign mux_s0      = op_q[0];
    assign add_cin     = cin_q;
    assign add_a       = acc_q;
    assign acc         = acc_q;
    assign resp_result = acc_q;
    assign resp_z      = z_q;
    assign resp_c      = c_q;
    assign resp_v      = v_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors, transaction-level model,
// and an external mux/adder so the loop is closed.
module tb_alu_sequencer;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic         req_load = 1'b0;
    logic [W-1:0] req_operand = '0;
    logic [W-1:0] mux_a;
    logic         mux_s1, mux_s0;
    logic [W-1:0] add_a;
    logic         add_cin;
    logic [W-1:0] sum_in;
    logic         cout_in;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_result;
    logic         resp_z, resp_c, resp_v;
    logic [W-1:0] acc;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .WIDTH  (W),
        .SETTLE (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_load    (req_load),
        .req_operand (req_operand),
        .mux_a       (mux_a),
        .mux_s1      (mux_s1),
        .mux_s0      (mux_s0),
        .add_a       (add_a),
        .add_cin     (add_cin),
        .sum_in      (sum_in),
        .cout_in     (cout_in),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_z      (resp_z),
        .resp_c      (resp_c),
        .resp_v      (resp_v),
        .acc         (acc)
    );

    // Operand mux and ripple adder downstream of the sequencer.
    logic [W-1:0] mux_b;
    always_comb begin
        mux_b = mux_a;
        case ({mux_s1, mux_s0})
            2'b00:   mux_b = mux_a;
            2'b01:   mux_b = ~mux_a;
            2'b10:   mux_b = '0;
            default: mux_b = '1;
        endcase
        {cout_in, sum_in} = 5'(add_a) + 5'(mux_b) + 5'(add_cin);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction model: plain integer arithmetic on accumulator.
    int m_acc = 0;
    int m_age = -1;
    bit m_resp = 1'b0;
    bit m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;
    int m_op = 0, m_b = 0;
    bit chk_en = 1'b0;

    initial begin
        int r, sa, sb, sr;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_acc = 0; m_age = -1; m_resp = 0;
                m_z = 0; m_c = 0; m_v = 0;
                chk_en = 1;
            end else if (m_resp) begin
                if (resp_ready) m_resp = 0;
            end else if (m_age >= 1) begin
                if (m_age == S + 1) begin
                    sa = (m_acc >= 8) ? m_acc - 16 : m_acc;
                    sb = (m_b >= 8) ? m_b - 16 : m_b;
                    case (m_op)
                        0: begin
                            r = m_acc + m_b; sr = sa + sb;
                            m_c = (r > 15);
                        end
                        1: begin
                            r = m_acc - m_b; sr = sa - sb;
                            m_c = (m_acc >= m_b);
                        end
                        2: begin
                            r = m_acc + 1; sr = sa + 1;
                            m_c = (m_acc == 15);
                        end
                        default: begin
                            r = m_acc - 1; sr = sa - 1;
                            m_c = (m_acc != 0);
                        end
                    endcase
                    m_acc = r & 15;
                    m_z = (m_acc == 0);
                    m_v = (sr > 7) || (sr < -8);
                    m_age = -1;
                    m_resp = 1;
                end else begin
                    m_age++;
                end
            end else if (req_valid) begin
                if (req_load) begin
                    m_acc = int'(req_operand);
                    m_z = (m_acc == 0); m_c = 0; m_v = 0;
                    m_resp = 1;
                end else begin
                    m_op = int'(req_op);
                    m_b = int'(req_operand);
                    m_age = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        bit drv;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                drv = (m_age >= 1) && (m_age <= S + 1);
                chk("req_ready", int'(req_ready),
                    int'(!rst && m_age < 0 && !m_resp));
                chk("resp_valid", int'(resp_valid), int'(m_resp));
                chk("acc", int'(acc), m_acc);
                chk("add_a", int'(add_a), m_acc);
                chk("mux_a", int'(mux_a), drv ? m_b : 0);
                chk("mux_sel", int'({mux_s1, mux_s0}), drv ? m_op : 0);
                chk("add_cin", int'(add_cin),
                    (drv && (m_op == 1 || m_op == 2)) ? 1 : 0);
                if (m_resp) begin
                    chk("resp_result", int'(resp_result), m_acc);
                    chk("resp_z", int'(resp_z), int'(m_z));
                    chk("resp_c", int'(resp_c), int'(m_c));
                    chk("resp_v", int'(resp_v), int'(m_v));
                end
            end
        end
    end

    task automatic send(input bit ld, input int op, input int b);
        bit ok, rdy;
        ok = 0;
        req_load = ld;
        req_op = 2'(op);
        req_operand = 4'(b);
        req_valid = 1;
        for (int i = 0; i < 40 && !ok; i++) begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1;
        end
        req_valid = 0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
    endtask

    task automatic finish_resp();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input string nm, input int res,
                               input int z, input int c, input int v);
        chk({nm, "_res"}, int'(resp_result), res);
        chk({nm, "_z"}, int'(resp_z), z);
        chk({nm, "_c"}, int'(resp_c), c);
        chk({nm, "_v"}, int'(resp_v), v);
    endtask

    initial begin
        int lat;
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", int'(acc), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_mux_a", int'(mux_a), 0);
        chk("rst_cin", int'(add_cin), 0);
        chk("rst_ready", int'(req_ready), 0);
        rst = 0;
        #1;
        chk("ready_after_rst", int'(req_ready), 1);
        @(posedge clk);
        #1;

        // load 5, add 3
        send(1, 0, 5);
        wait_resp(lat);
        chk("load_latency", lat, 0);
        expect_resp("load5", 5, 0, 0, 0);
        finish_resp();
        send(0, 0, 3);
        chk("add_mux_a", int'(mux_a), 3);
        chk("add_sel", int'({mux_s1, mux_s0}), 0);
        wait_resp(lat);
        chk("add_latency", lat, S + 1);
        expect_resp("add3", 8, 0, 0, 1);
        finish_resp();

        // sub 8 from 8
        send(0, 1, 8);
        chk("sub_sel", int'({mux_s1, mux_s0}), 1);
        chk("sub_cin", int'(add_cin), 1);
        wait_resp(lat);
        expect_resp("sub8", 0, 1, 1, 0);
        finish_resp();

        // inc wrap then dec wrap
        send(1, 0, 15);
        wait_resp(lat);
        finish_resp();
        send(0, 2, 0);
        wait_resp(lat);
        expect_resp("inc15", 0, 1, 1, 0);
        finish_resp();
        send(0, 3, 0);
        wait_resp(lat);
        expect_resp("dec0", 15, 0, 0, 0);
        finish_resp();

        // signed overflow on sub, and a plain add
        send(1, 0, 8);
        wait_resp(lat);
        finish_resp();
        send(0, 1, 1);
        wait_resp(lat);
        expect_resp("sub_ovf", 7, 0, 1, 1);
        finish_resp();
        send(0, 0, 9);
        wait_resp(lat);
        expect_resp("add9", 0, 1, 1, 0);
        finish_resp();

        // backpressure with a competing request held high
        send(1, 0, 2);
        wait_resp(lat);
        finish_resp();
        resp_ready = 0;
        send(0, 0, 1);
        wait_resp(lat);
        req_load = 0; req_op = 2'b00; req_operand = 4'd4;
        req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            expect_resp("bp", 3, 0, 0, 0);
            chk("bp_ready", int'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        chk("bp_valid_held", int'(resp_valid), 1);
        req_valid = 0;
        resp_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_done_valid", int'(resp_valid), 0);
        chk("bp_done_acc", int'(acc), 3);

        // reset in the second DRIVE cycle of add 7
        send(0, 0, 7);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("mid_rst_acc", int'(acc), 0);
        chk("mid_rst_mux_a", int'(mux_a), 0);
        for (int i = 0; i < 5; i++) begin
            chk("mid_rst_no_resp", int'(resp_valid), 0);
            @(posedge clk);
            #1;
        end
        send(0, 0, 1);
        wait_resp(lat);
        expect_resp("post_rst_add1", 1, 0, 0, 0);
        finish_resp();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, expected finish");
        $fatal(1);
    end

endmodule
